// File: rtl/irq_pending_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : irq_pending_ctrl_pkg                                         |
// | Description : Shared widths, FSM state encoding and helpers for the IRQ    |
// |               pending controller and its synchroniser sub-block.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package irq_pending_ctrl_pkg;

  localparam int IRQ_NUM  = 16;
  localparam int IRQ_ID_W = 4;

  // Request/acknowledge/complete handshake states
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  // One-hot vector with only bit `id` set
  function automatic logic [IRQ_NUM-1:0] id_onehot(input logic [IRQ_ID_W-1:0] id);
    return {{(IRQ_NUM-1){1'b0}}, 1'b1} << id;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : irq_sync_edge                                                |
// | Description : Per-line multi-flop synchroniser followed by a rising-edge   |
// |               detector. With IRQ_LEVEL_MODE_EN defined the edge detector   |
// |               is removed and the synchronised level is passed through.     |
// | Ports       : clk        - system clock                                    |
// |               rst_n      - asynchronous active-low reset                   |
// |               irq_src_i  - raw asynchronous IRQ lines                      |
// |               irq_evt_o  - edge pulses (level vector in level mode)        |
// | Macro       : IRQ_LEVEL_MODE_EN                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module irq_sync_edge
  import irq_pending_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2   // must be >= 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IRQ_NUM-1:0] irq_src_i,
  output logic [IRQ_NUM-1:0] irq_evt_o
);

  // Stage 0 is the metastability-catching flop; stage SYNC_STAGES-1 is safe to use
  logic [SYNC_STAGES-1:0][IRQ_NUM-1:0] sync_q;
  logic [IRQ_NUM-1:0]                  sync_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_src_i};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef IRQ_LEVEL_MODE_EN
  assign irq_evt_o = sync_out;
`else
  logic [IRQ_NUM-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
    end else begin
      prev_q <= sync_out;
    end
  end

  assign irq_evt_o = sync_out & ~prev_q;
`endif

endmodule
`default_nettype wire

// File: rtl/irq_pending_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : irq_pending_ctrl                                             |
// | Description : Interrupt front end for 16 peripheral lines. Synchronises    |
// |               and captures interrupts into a pending register, applies the |
// |               enable mask towards an external priority encoder, and runs   |
// |               the request/ack/done handshake with the core trap logic.     |
// | Ports       : clk, rst_n            - clock, async active-low reset        |
// |               irq_src               - raw peripheral IRQ lines             |
// |               mask_we, mask_wdata   - enable mask write port               |
// |               irq_mask              - current enable mask                  |
// |               pend_masked           - pending & mask, to the encoder       |
// |               enc_num, enc_en       - encoder result (combinational)       |
// |               irq_req, irq_id       - request and index to the core        |
// |               irq_ack, irq_done     - trap taken / handler return pulses   |
// | Macro       : IRQ_LEVEL_MODE_EN (level-sensitive sources, no ack clear)    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module irq_pending_ctrl
  import irq_pending_ctrl_pkg::*;
#(
  parameter int unsigned        SYNC_STAGES = 2,
  parameter logic [IRQ_NUM-1:0] MASK_RST    = 16'h0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IRQ_NUM-1:0]  irq_src,
  input  logic                mask_we,
  input  logic [IRQ_NUM-1:0]  mask_wdata,
  output logic [IRQ_NUM-1:0]  irq_mask,
  output logic [IRQ_NUM-1:0]  pend_masked,
  input  logic [IRQ_ID_W-1:0] enc_num,
  input  logic                enc_en,
  output logic                irq_req,
  output logic [IRQ_ID_W-1:0] irq_id,
  input  logic                irq_ack,
  input  logic                irq_done
);

  logic [IRQ_NUM-1:0]  evt;
  logic [IRQ_NUM-1:0]  pending_q, pending_d;
  logic [IRQ_NUM-1:0]  mask_q, mask_d;
  logic [1:0]          state_q, state_d;
  logic [IRQ_ID_W-1:0] irq_id_q, irq_id_d;

  irq_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_src_i (irq_src),
    .irq_evt_o (evt)
  );

  // Pending capture is independent of the mask so masked sources are not lost
`ifdef IRQ_LEVEL_MODE_EN
  assign pending_d = evt;
`else
  logic ack_take;

  // An ack only counts while the request is still valid; a simultaneous
  // withdraw (enc_en low) cancels it.
  assign ack_take  = (state_q == REQ) && enc_en && irq_ack;
  // OR-ing the new edge after the clear lets a colliding set win
  assign pending_d = (pending_q & ~(ack_take ? id_onehot(irq_id_q) : '0)) | evt;
`endif

  assign mask_d = mask_we ? mask_wdata : mask_q;

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    case (state_q)
      IDLE: begin
        if (enc_en) begin
          state_d  = REQ;
          irq_id_d = enc_num;
        end
      end
      REQ: begin
        if (!enc_en) begin
          state_d = IDLE;
        end else if (irq_ack) begin
          state_d = SERVICE;        // irq_id frozen at the acked index
        end else begin
          irq_id_d = enc_num;       // track higher-priority arrivals
        end
      end
      SERVICE: begin
        if (irq_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      mask_q    <= MASK_RST;
      state_q   <= IDLE;
      irq_id_q  <= '0;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      state_q   <= state_d;
      irq_id_q  <= irq_id_d;
    end
  end

  assign irq_mask    = mask_q;
  assign pend_masked = pending_q & mask_q;
  assign irq_req     = (state_q == REQ);
  assign irq_id      = irq_id_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_pending_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_irq_pending_ctrl                                          |
// | Description : Self-checking bench for irq_pending_ctrl with an external    |
// |               priority encoder model and a behavioural reference model.    |
// | Macro       : IRQ_LEVEL_MODE_EN (reference model follows the DUT build)    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_irq_pending_ctrl;

  localparam int          S    = 2;
  localparam logic [15:0] MRST = 16'h0000;

  typedef struct packed {
    logic [15:0] src;
    logic        mwe;
    logic [15:0] wd;
    logic        ack;
    logic        done;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] irq_src, mask_wdata, irq_mask, pend_masked;
  logic        mask_we, enc_en, irq_req, irq_ack, irq_done;
  logic [3:0]  enc_num, irq_id;

  int vecs = 0;
  int errs = 0;

  // Reference model state
  logic [15:0] m_pend, m_mask;
  logic [15:0] m_hist[$];   // m_hist[j] = irq_src sampled j edges ago
  bit          m_req, m_svc;
  logic [3:0]  m_id;

  always #5 clk = ~clk;

  irq_pending_ctrl #(.SYNC_STAGES(S), .MASK_RST(MRST)) dut (
    .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .irq_mask(irq_mask), .pend_masked(pend_masked),
    .enc_num(enc_num), .enc_en(enc_en), .irq_req(irq_req), .irq_id(irq_id),
    .irq_ack(irq_ack), .irq_done(irq_done)
  );

  // External 16-to-4 priority encoder: highest set bit wins
  always_comb begin
    enc_en  = |pend_masked;
    enc_num = 4'd0;
    for (int i = 0; i < 16; i++) if (pend_masked[i]) enc_num = 4'(i);
  end

  function automatic int top_bit(input logic [15:0] v);
    int r = -1;
    for (int i = 0; i < 16; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic stim_t mk(input logic [15:0] src, input logic mwe,
                               input logic [15:0] wd, input logic ack, input logic done);
    return {src, mwe, wd, ack, done};
  endfunction

  task automatic m_reset();
    m_pend = '0; m_mask = MRST; m_req = 0; m_svc = 0; m_id = '0;
    m_hist = {};
    for (int i = 0; i < S + 2; i++) m_hist.push_back(16'h0);
  endtask

  task automatic do_reset();
    irq_src = '0; mask_we = 0; mask_wdata = '0; irq_ack = 0; irq_done = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_reset();
  endtask

  // Apply one cycle of stimulus to DUT and model; returns 1 time unit after the edge
  task automatic step(input stim_t s);
    logic [15:0] pm;
    int          hb;
`ifndef IRQ_LEVEL_MODE_EN
    logic [15:0] edg, clr;
`endif
    irq_src = s.src; mask_we = s.mwe; mask_wdata = s.wd; irq_ack = s.ack; irq_done = s.done;
    @(posedge clk);
    pm = m_pend & m_mask;
    hb = top_bit(pm);
    m_hist.push_front(s.src);
    void'(m_hist.pop_back());
`ifdef IRQ_LEVEL_MODE_EN
    m_pend = m_hist[S];
`else
    edg    = m_hist[S] & ~m_hist[S+1];
    clr    = (m_req && s.ack && hb >= 0) ? (16'h1 << m_id) : 16'h0;
    m_pend = (m_pend & ~clr) | edg;
`endif
    if (m_req) begin
      if (hb < 0) m_req = 0;
      else if (s.ack) begin m_req = 0; m_svc = 1; end
      else m_id = 4'(hb);
    end else if (m_svc) begin
      if (s.done) m_svc = 0;
    end else if (hb >= 0) begin
      m_req = 1; m_id = 4'(hb);
    end
    if (s.mwe) m_mask = s.wd;
    #1;
  endtask

  task automatic test_reset();
    irq_src = '0; mask_we = 0; mask_wdata = '0; irq_ack = 0; irq_done = 0;
    rst_n = 1'b0;
    #2;
    vecs++;
    if ({irq_req, irq_id, irq_mask, pend_masked} !== {1'b0, 4'd0, MRST, 16'h0}) begin
      errs++;
      $display("FAIL reset_state: req=%b id=%0d mask=%h pm=%h, want 0/0/%h/0000",
               irq_req, irq_id, irq_mask, pend_masked, MRST);
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(mk(16'h0, 0, 16'h0, 0, 0));
      vecs++;
      if ({irq_req, irq_id, irq_mask, pend_masked} !== {m_req, m_id, m_mask, m_pend & m_mask}) begin
        errs++;
        $display("FAIL reset_idle cyc %0d: got %b/%0d/%h/%h want %b/%0d/%h/%h", i,
                 irq_req, irq_id, irq_mask, pend_masked, m_req, m_id, m_mask, m_pend & m_mask);
      end
    end
  endtask

  task automatic test_single_edge();
    stim_t st[$];
    do_reset();
    st.push_back(mk(16'h0, 1, 16'h0010, 0, 0));
    st.push_back(mk(16'h0010, 0, 16'h0, 0, 0));            // first sampling edge
    for (int k = 0; k < S + 1; k++) st.push_back(mk(16'h0, 0, 16'h0, 0, 0));
    st.push_back(mk(16'h0, 0, 16'h0, 1, 0));               // ack
    st.push_back(mk(16'h0, 0, 16'h0, 0, 0));
    st.push_back(mk(16'h0, 0, 16'h0, 0, 1));               // done
    st.push_back(mk(16'h0, 0, 16'h0, 0, 0));
    foreach (st[i]) begin
      step(st[i]);
      vecs++;
      if ({irq_req, irq_id, irq_mask, pend_masked} !== {m_req, m_id, m_mask, m_pend & m_mask}) begin
        errs++;
        $display("FAIL single_edge cyc %0d: got %b/%0d/%h/%h want %b/%0d/%h/%h", i,
                 irq_req, irq_id, irq_mask, pend_masked, m_req, m_id, m_mask, m_pend & m_mask);
      end
`ifndef IRQ_LEVEL_MODE_EN
      if (i == 1 + S) begin
        vecs++;
        if (irq_req !== 1'b0 || pend_masked !== 16'h0010) begin
          errs++;
          $display("FAIL single_edge_early: req=%b pm=%h, want req=0 pm=0010", irq_req, pend_masked);
        end
      end
      if (i == 2 + S) begin
        vecs++;
        if (irq_req !== 1'b1 || irq_id !== 4'd4) begin
          errs++;
          $display("FAIL single_edge_latency: req=%b id=%0d, want req=1 id=4", irq_req, irq_id);
        end
      end
      if (i == 3 + S) begin
        vecs++;
        if (irq_req !== 1'b0 || pend_masked !== 16'h0 || irq_id !== 4'd4) begin
          errs++;
          $display("FAIL single_edge_ack: req=%b id=%0d pm=%h, want 0/4/0000", irq_req, irq_id, pend_masked);
        end
      end
`endif
    end
  endtask

  task automatic test_priority();
    stim_t st[$];
    do_reset();
    st.push_back(mk(16'h0, 1, 16'hFFFF, 0, 0));
    st.push_back(mk(16'h0008, 0, 16'h0, 0, 0));
    for (int k = 0; k < S + 1; k++) st.push_back(mk(16'h0, 0, 16'h0, 0, 0));
    st.push_back(mk(16'h1000, 0, 16'h0, 0, 0));            // index S+3
    for (int k = 0; k < S + 1; k++) st.push_back(mk(16'h0, 0, 16'h0, 0, 0));
    st.push_back(mk(16'h0, 0, 16'h0, 1, 0));               // ack, index 2S+5
    st.push_back(mk(16'h0, 0, 16'h0, 0, 0));
    st.push_back(mk(16'h0, 0, 16'h0, 0, 1));               // done
    st.push_back(mk(16'h0, 0, 16'h0, 0, 0));               // index 2S+8
    foreach (st[i]) begin
      step(st[i]);
      vecs++;
      if ({irq_req, irq_id, irq_mask, pend_masked} !== {m_req, m_id, m_mask, m_pend & m_mask}) begin
        errs++;
        $display("FAIL priority cyc %0d: got %b/%0d/%h/%h want %b/%0d/%h/%h", i,
                 irq_req, irq_id, irq_mask, pend_masked, m_req, m_id, m_mask, m_pend & m_mask);
      end
`ifndef IRQ_LEVEL_MODE_EN
      if (i == S + 2 || i == 2 * S + 4 || i == 2 * S + 8) begin
        vecs++;
        if (irq_req !== 1'b1 || irq_id !== ((i == 2 * S + 4) ? 4'd12 : 4'd3)) begin
          errs++;
          $display("FAIL priority_id cyc %0d: req=%b id=%0d, want req=1 id=%0d", i, irq_req, irq_id,
                   (i == 2 * S + 4) ? 12 : 3);
        end
      end
      if (i == 2 * S + 5) begin
        vecs++;
        if (irq_req !== 1'b0 || pend_masked !== 16'h0008) begin
          errs++;
          $display("FAIL priority_ack: req=%b pm=%h, want req=0 pm=0008", irq_req, pend_masked);
        end
      end
`endif
    end
  endtask

  task automatic test_masked_capture();
    stim_t st[$];
    do_reset();
    st.push_back(mk(16'h0080, 0, 16'h0, 0, 0));
    for (int k = 0; k < S + 3; k++) st.push_back(mk(16'h0, 0, 16'h0, 0, 0));
    st.push_back(mk(16'h0, 1, 16'h0080, 0, 0));            // index S+4
    st.push_back(mk(16'h0, 0, 16'h0, 0, 0));               // index S+5
    foreach (st[i]) begin
      step(st[i]);
      vecs++;
      if ({irq_req, irq_id, irq_mask, pend_masked} !== {m_req, m_id, m_mask, m_pend & m_mask}) begin
        errs++;
        $display("FAIL masked_capture cyc %0d: got %b/%0d/%h/%h want %b/%0d/%h/%h", i,
                 irq_req, irq_id, irq_mask, pend_masked, m_req, m_id, m_mask, m_pend & m_mask);
      end
`ifndef IRQ_LEVEL_MODE_EN
      if (i <= S + 4) begin
        vecs++;
        if (irq_req !== 1'b0) begin
          errs++;
          $display("FAIL masked_no_req cyc %0d: req=%b, want 0", i, irq_req);
        end
      end
      if (i == S + 5) begin
        vecs++;
        if (irq_req !== 1'b1 || irq_id !== 4'd7) begin
          errs++;
          $display("FAIL masked_unmask: req=%b id=%0d, want req=1 id=7", irq_req, irq_id);
        end
      end
`endif
    end
  endtask

  task automatic test_withdraw();
    stim_t st[$];
    do_reset();
    st.push_back(mk(16'h0, 1, 16'h0200, 0, 0));
    st.push_back(mk(16'h0200, 0, 16'h0, 0, 0));
    for (int k = 0; k < S + 1; k++) st.push_back(mk(16'h0, 0, 16'h0, 0, 0));
    st.push_back(mk(16'h0, 1, 16'h0000, 0, 0));            // index S+3: mask off
    st.push_back(mk(16'h0, 1, 16'hFFFF, 0, 0));            // index S+4: unmask all
    st.push_back(mk(16'h0, 0, 16'h0, 0, 0));               // index S+5
    foreach (st[i]) begin
      step(st[i]);
      vecs++;
      if ({irq_req, irq_id, irq_mask, pend_masked} !== {m_req, m_id, m_mask, m_pend & m_mask}) begin
        errs++;
        $display("FAIL withdraw cyc %0d: got %b/%0d/%h/%h want %b/%0d/%h/%h", i,
                 irq_req, irq_id, irq_mask, pend_masked, m_req, m_id, m_mask, m_pend & m_mask);
      end
`ifndef IRQ_LEVEL_MODE_EN
      if (i == S + 3) begin
        vecs++;
        if (irq_req !== 1'b1 || irq_id !== 4'd9) begin
          errs++;
          $display("FAIL withdraw_hold: req=%b id=%0d, want req=1 id=9", irq_req, irq_id);
        end
      end
      if (i == S + 4) begin
        vecs++;
        if (irq_req !== 1'b0 || pend_masked !== 16'h0200) begin
          errs++;
          $display("FAIL withdraw_drop: req=%b pm=%h, want req=0 pm=0200", irq_req, pend_masked);
        end
      end
`endif
    end
  endtask

  task automatic test_collision();
    stim_t st[$];
    do_reset();
    st.push_back(mk(16'h0, 1, 16'h0004, 0, 0));
    st.push_back(mk(16'h0004, 0, 16'h0, 0, 0));
    for (int k = 0; k < S + 1; k++) st.push_back(mk(16'h0, 0, 16'h0, 0, 0));
    st.push_back(mk(16'h0004, 0, 16'h0, 0, 0));            // index S+3: second edge
    for (int k = 0; k < S - 1; k++) st.push_back(mk(16'h0, 0, 16'h0, 0, 0));
    st.push_back(mk(16'h0, 0, 16'h0, 1, 0));               // index 2S+3: ack meets edge
    st.push_back(mk(16'h0, 0, 16'h0, 0, 1));               // done
    st.push_back(mk(16'h0, 0, 16'h0, 0, 0));               // index 2S+5
    foreach (st[i]) begin
      step(st[i]);
      vecs++;
      if ({irq_req, irq_id, irq_mask, pend_masked} !== {m_req, m_id, m_mask, m_pend & m_mask}) begin
        errs++;
        $display("FAIL collision cyc %0d: got %b/%0d/%h/%h want %b/%0d/%h/%h", i,
                 irq_req, irq_id, irq_mask, pend_masked, m_req, m_id, m_mask, m_pend & m_mask);
      end
`ifndef IRQ_LEVEL_MODE_EN
      if (i == 2 * S + 3) begin
        vecs++;
        if (irq_req !== 1'b0 || pend_masked !== 16'h0004) begin
          errs++;
          $display("FAIL collision_set_wins: req=%b pm=%h, want req=0 pm=0004", irq_req, pend_masked);
        end
      end
      if (i == 2 * S + 5) begin
        vecs++;
        if (irq_req !== 1'b1 || irq_id !== 4'd2) begin
          errs++;
          $display("FAIL collision_rereq: req=%b id=%0d, want req=1 id=2", irq_req, irq_id);
        end
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    stim_t st[$];
    do_reset();
    st.push_back(mk(16'h0, 1, 16'hFFFF, 0, 0));
    st.push_back(mk(16'h0020, 0, 16'h0, 0, 0));
    for (int k = 0; k < S + 1; k++) st.push_back(mk(16'h0020, 0, 16'h0, 0, 0));
    st.push_back(mk(16'h0020, 0, 16'h0, 1, 0));            // enter SERVICE
    foreach (st[i]) begin
      step(st[i]);
      vecs++;
      if ({irq_req, irq_id, irq_mask, pend_masked} !== {m_req, m_id, m_mask, m_pend & m_mask}) begin
        errs++;
        $display("FAIL async_reset_setup cyc %0d: got %b/%0d/%h/%h want %b/%0d/%h/%h", i,
                 irq_req, irq_id, irq_mask, pend_masked, m_req, m_id, m_mask, m_pend & m_mask);
      end
    end
    #2 rst_n = 1'b0;       // mid-cycle, no clock edge until the check
    #1;
    vecs++;
    if ({irq_req, irq_id, irq_mask, pend_masked} !== {1'b0, 4'd0, MRST, 16'h0} ||
        dut.pending_q !== 16'h0) begin
      errs++;
      $display("FAIL async_reset: req=%b id=%0d mask=%h pm=%h pend=%h, want 0/0/%h/0000/0000",
               irq_req, irq_id, irq_mask, pend_masked, dut.pending_q, MRST);
    end
  endtask

  task automatic test_random();
    logic [15:0] src = '0;
    logic        mwe, ack, done;
    logic [15:0] wd;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(2, 0) == 0) src = src ^ (16'h1 << $urandom_range(15, 0));
      mwe  = ($urandom_range(7, 0) == 0);
      wd   = 16'($urandom);
      ack  = irq_req ? ($urandom_range(1, 0) == 0) : ($urandom_range(15, 0) == 0);
      done = ($urandom_range(5, 0) == 0);
      step(mk(src, mwe, wd, ack, done));
      vecs++;
      if ({irq_req, irq_id, irq_mask, pend_masked} !== {m_req, m_id, m_mask, m_pend & m_mask}) begin
        errs++;
        $display("FAIL random cyc %0d: got %b/%0d/%h/%h want %b/%0d/%h/%h", i,
                 irq_req, irq_id, irq_mask, pend_masked, m_req, m_id, m_mask, m_pend & m_mask);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_priority();
    test_masked_capture();
    test_withdraw();
    test_collision();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
